wb_stage: RTL
=============

# wb_stage

Writeback stage of the dCPU pipeline, directly upstream of the register file. It accepts retiring instructions from execute, either ALU results or loads. For loads it waits for the data-memory read response, then aligns and sign/zero-extends the data. Its registered `wren`/`rd_addr`/`reg_data` outputs drive the register file write port one cycle later.

## Interface
- `TIMEOUT_CYCLES`, 16: load-response watchdog limit in cycles; only used when `WB_LOAD_TIMEOUT_EN` is defined; must be ≥2.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `ex_valid  in  1`: execute presents an instruction.
- `ex_ready  out  1`: combinational; high exactly when the FSM is in IDLE. A transfer occurs when `ex_valid && ex_ready`.
- `ex_rd  in  5`: destination register.
- `ex_result  in  32`: ALU result; ignored for loads.
- `ex_is_load  in  1`: instruction is a load.
- `ex_funct3  in  3`: load type.
- `ex_addr_lo  in  2`: byte address bits [1:0] of the load.
- `mem_rvalid  in  1`: data-memory read data valid.
- `mem_rdata  in  32`: little-endian read word.
- `wren  out  1`: register file write enable.
- `rd_addr  out  5`: register file write address.
- `reg_data  out  32`: register file write data.
- `wb_retire  out  1`: one-cycle pulse per completed instruction, including writes to x0.
- `load_err  out  1`: one-cycle pulse when a load times out (only with `WB_LOAD_TIMEOUT_EN`; otherwise tied 0).

## Operation
**FSM states**
- **IDLE**
  - Non-load transfer: next cycle `wren = (ex_rd != 0)`, `rd_addr = ex_rd`, `reg_data = ex_result`, `wb_retire = 1`. FSM stays in IDLE.
  - Load transfer: the FSM latches `ex_rd`, `ex_funct3` and `ex_addr_lo`, then moves to WAIT_LOAD.
- **WAIT_LOAD**
  - `ex_ready = 0`.
  - On `mem_rvalid`: the aligned data is written next cycle, with the same rules as the non-load case. FSM returns to IDLE.

**Load alignment** (`mem_rdata` indexed by byte lane)
- `000` LB: byte `ex_addr_lo`, sign-extended.
- `100` LBU: byte `ex_addr_lo`, zero-extended.
- `001` LH: half selected by `addr_lo[1]`, sign-extended; `addr_lo[0]` ignored.
- `101` LHU: half selected by `addr_lo[1]`, zero-extended; `addr_lo[0]` ignored.
- `010` LW, and illegal `011`/`110`/`111`: full word; `addr_lo` ignored.

**Boundary conditions**
- `mem_rvalid` in IDLE is ignored. This includes a `mem_rvalid` in the same cycle as a load transfer.
- `rd == 0`: `wren` stays 0, but `rd_addr`/`reg_data` still update and `wb_retire` still pulses.
- `rst` during WAIT_LOAD: the pending load is dropped and no write occurs. A `mem_rvalid` arriving after reset release is ignored.
- `wren`, `wb_retire` and `load_err` are single-cycle pulses.
- `rd_addr`/`reg_data` hold their last value between writes.

## Timing
- Reset values: FSM in IDLE; `wren=0`, `rd_addr=0`, `reg_data=0`, `wb_retire=0`, `load_err=0`. `ex_ready` reads 1 once in IDLE.
- ALU latency: write 1 cycle after the transfer. Throughput is one ALU instruction per cycle, back-to-back.
- Load latency: write 1 cycle after the `mem_rvalid` cycle.
- `ex_ready` rises in the cycle the load write is presented, so the next transfer may overlap that write.
- No combinational path from `mem_rdata` or `ex_*` to `wren`/`rd_addr`/`reg_data`.

## Configuration
- `WB_LOAD_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without `mem_rvalid`.
  - When it reaches `TIMEOUT_CYCLES`, the next cycle has `load_err = 1`, `wren = 0` and `wb_retire = 0`, and the FSM returns to IDLE.
  - `mem_rvalid` in the same cycle the count is reached takes priority: normal write, no error.
- `WB_LOAD_TIMEOUT_EN` undefined: no counter, `load_err` is constant 0, and WAIT_LOAD waits indefinitely.

## Structure
- Shared package `dcpu_pkg` holds:
  - load funct3 constants `F3_LB`/`F3_LH`/`F3_LW`/`F3_LBU`/`F3_LHU`;
  - the `wb_state_t` encoding (IDLE, WAIT_LOAD);
  - the common `ENABLE`/`DISABLE` definitions.
- One sub-module, `load_align`: purely combinational `(rdata, funct3, addr_lo) -> data32`. It is unit-testable on its own.

## Test plan
- Reset, then ALU `rd=5`, `result=0xDEADBEEF` → next cycle `wren=1`, `rd_addr=5`, `reg_data=0xDEADBEEF`, `wb_retire=1`.
- Three back-to-back ALU instructions (`rd=1,2,3`) → three consecutive writes; `ex_ready` stays 1 throughout.
- LB with `addr_lo=3`, `mem_rdata=0x80FF1234` after 3 wait cycles → `ex_ready=0` while waiting; write `0xFFFFFF80`. LHU with `addr_lo=2`, same data → `0x000080FF`.
- ALU with `rd=0` → `wren=0`, `wb_retire=1`. `mem_rvalid` pulsed in IDLE → no write.
- `rst` asserted during WAIT_LOAD, then `mem_rvalid` after release → no write; all outputs at reset values.
- With `WB_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, and no response → `load_err` pulses after the 4th wait cycle, no write, then `ex_ready=1`.

Source files
------------

// File: rtl/dcpu_pkg.sv
// Shared dCPU definitions: load funct3 codes, writeback FSM encoding and
// the common enable/disable constants.
package dcpu_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner: selects the byte/half/word lane from a
// little-endian read word and sign- or zero-extends it to 32 bits.
module load_align
  import dcpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data32
);

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] r;
    r = b;
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    logic signed [31:0] r;
    r = h;
    return r;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Half-word lane ignores addr_lo[0]; misaligned halves read the aligned half.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data32 = rdata;
    case (funct3)
      F3_LB:   data32 = sext8(byte_sel);
      F3_LBU:  data32 = {24'd0, byte_sel};
      F3_LH:   data32 = sext16(half_sel);
      F3_LHU:  data32 = {16'd0, half_sel};
      default: data32 = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// dCPU writeback stage: retires ALU results and loads into the register file
// write port. Optional load-response watchdog enabled by WB_LOAD_TIMEOUT_EN.
module wb_stage
  import dcpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wren,
  output logic [4:0]  rd_addr,
  output logic [31:0] reg_data,
  output logic        wb_retire,
  output logic        load_err
);

  wb_state_t   state_q, state_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        wren_q, wren_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] reg_data_q, reg_data_d;
  logic        retire_q, retire_d;
  logic        load_err_d;
  logic [31:0] aligned;

  // Aligner sees latched load attributes, so ex_* may change while waiting.
  load_align u_align (
    .rdata   (mem_rdata),
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .data32  (aligned)
  );

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_err_q;
`endif

  assign ex_ready = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    wren_d     = DISABLE;
    retire_d   = DISABLE;
    load_err_d = DISABLE;
    rd_addr_d  = rd_addr_q;
    reg_data_d = reg_data_q;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            ld_rd_d = ex_rd;
            ld_f3_d = ex_funct3;
            ld_lo_d = ex_addr_lo;
            state_d = WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            wren_d     = (ex_rd != 5'd0);
            rd_addr_d  = ex_rd;
            reg_data_d = ex_result;
            retire_d   = ENABLE;
          end
        end
      end
      WAIT_LOAD: begin
        // A response in the same cycle the watchdog expires still wins.
        if (mem_rvalid) begin
          wren_d     = (ld_rd_q != 5'd0);
          rd_addr_d  = ld_rd_q;
          reg_data_d = aligned;
          retire_d   = ENABLE;
          state_d    = IDLE;
        end
`ifdef WB_LOAD_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          load_err_d = ENABLE;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_rd_q    <= 5'd0;
      ld_f3_q    <= 3'd0;
      ld_lo_q    <= 2'd0;
      wren_q     <= DISABLE;
      rd_addr_q  <= 5'd0;
      reg_data_q <= 32'd0;
      retire_q   <= DISABLE;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_lo_q    <= ld_lo_d;
      wren_q     <= wren_d;
      rd_addr_q  <= rd_addr_d;
      reg_data_q <= reg_data_d;
      retire_q   <= retire_d;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      load_err_q <= DISABLE;
    end else begin
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end
  assign load_err = load_err_q;
`else
  assign load_err = DISABLE;
`endif

  assign wren      = wren_q;
  assign rd_addr   = rd_addr_q;
  assign reg_data  = reg_data_q;
  assign wb_retire = retire_q;

endmodule
